// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: parametrised Avalon-MM general-purpose I/O peripheral.
// Provides a data output register with atomic set/clear aliases, per-bit
// direction (driven out as output enables), a synchronised input path,
// edge capture with write-1-to-clear, and a maskable interrupt.

module avalon_pio_gen #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] DIR_RESET   = {WIDTH{1'b1}},
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      IRQ_TYPE    = 1,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  // Register word addresses.
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Architectural state.
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edge_cap_r;

  // Input path state: synchroniser chain (stage 0 samples the pad) and
  // a one-cycle delayed copy of the synchronised value for edge detection.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  in_dly_r;

  // Combinational helpers.
  logic             wr_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] in_sync_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] data_next_s;
  logic [WIDTH-1:0] dir_next_s;
  logic [WIDTH-1:0] mask_next_s;
  logic [WIDTH-1:0] edge_clr_s;
  logic [WIDTH-1:0] edge_next_s;
  logic [31:0]      rd_s;
  logic             irq_s;

  // Upper writedata bits are architecturally ignored when WIDTH < 32;
  // fold the whole bus into one sink so narrow builds stay lint-clean.
  logic unused_wdata_s;
  assign unused_wdata_s = ^writedata;

  assign wr_s      = chipselect & ~write_n;
  assign wr_data_s = writedata[WIDTH-1:0];
  assign in_sync_s = sync_r[SYNC_STAGES-1];
  assign rise_s    = in_sync_s & ~in_dly_r;
  assign fall_s    = ~in_sync_s & in_dly_r;

  // Select which transitions count as a captured edge.
  always_comb begin
    edge_s = ZERO_W;
    case (EDGE_TYPE)
      0:       edge_s = rise_s;
      1:       edge_s = fall_s;
      default: edge_s = rise_s | fall_s;
    endcase
  end

  // Next value of data_out: plain load, atomic set, atomic clear, or hold.
  // All three act on the registered value so back-to-back writes compose.
  always_comb begin
    data_next_s = data_out_r;
    if (wr_s) begin
      case (address)
        ADDR_DATA:   data_next_s = wr_data_s;
        ADDR_OUTSET: data_next_s = data_out_r | wr_data_s;
        ADDR_OUTCLR: data_next_s = data_out_r & ~wr_data_s;
        default:     data_next_s = data_out_r;
      endcase
    end else begin
      data_next_s = data_out_r;
    end
  end

  // Next values of direction and interrupt mask (plain read/write registers).
  always_comb begin
    dir_next_s  = dir_r;
    mask_next_s = mask_r;
    if (wr_s && (address == ADDR_DIR)) begin
      dir_next_s = wr_data_s;
    end else begin
      dir_next_s = dir_r;
    end
    if (wr_s && (address == ADDR_MASK)) begin
      mask_next_s = wr_data_s;
    end else begin
      mask_next_s = mask_r;
    end
  end

  // Edge capture: write-1-to-clear first, then OR in new edges so a capture
  // arriving in the same cycle as a clear of that bit wins.
  always_comb begin
    edge_clr_s = ZERO_W;
    if (wr_s && (address == ADDR_EDGE)) begin
      edge_clr_s = wr_data_s;
    end else begin
      edge_clr_s = ZERO_W;
    end
    edge_next_s = (edge_cap_r & ~edge_clr_s) | edge_s;
  end

  // Software-visible registers, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= RESET_VALUE;
      dir_r      <= DIR_RESET;
      mask_r     <= ZERO_W;
      edge_cap_r <= ZERO_W;
    end else begin
      data_out_r <= data_next_s;
      dir_r      <= dir_next_s;
      mask_r     <= mask_next_s;
      edge_cap_r <= edge_next_s;
    end
  end

  // Input synchroniser chain and edge-detect delay register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r   <= {(SYNC_STAGES*WIDTH){1'b0}};
      in_dly_r <= ZERO_W;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], in_port};
      in_dly_r <= in_sync_s;
    end
  end

  // Read mux: depends only on address and register state, never on
  // chipselect; bits above WIDTH stay zero.
  always_comb begin
    rd_s = 32'h0000_0000;
    case (address)
      ADDR_DATA: rd_s[WIDTH-1:0] = (dir_r & data_out_r) | (~dir_r & in_sync_s);
      ADDR_DIR:  rd_s[WIDTH-1:0] = dir_r;
      ADDR_MASK: rd_s[WIDTH-1:0] = mask_r;
      ADDR_EDGE: rd_s[WIDTH-1:0] = edge_cap_r;
      default:   rd_s = 32'h0000_0000;
    endcase
  end

  // Interrupt source: masked synchronised level or masked edge capture;
  // both come straight from flops, so irq does not glitch within a cycle.
  always_comb begin
    irq_s = 1'b0;
    if (IRQ_TYPE == 0) begin
      irq_s = |(in_sync_s & mask_r);
    end else begin
      irq_s = |(edge_cap_r & mask_r);
    end
  end

  assign readdata = rd_s;
  assign out_port = data_out_r;
  assign out_en   = dir_r;
  assign irq      = irq_s;

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Directed self-checking bench for avalon_pio_gen. Two instances share all
// inputs: "dut" uses edge-capture interrupts, "dut_lvl" uses level
// interrupts; both have RESET_VALUE = 0xA5 and DIR_RESET = 0xFF.

module tb_avalon_pio_gen;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;

  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic [7:0]  out_en;
  logic        irq;

  logic [31:0] readdata_lvl;
  logic [7:0]  out_port_lvl;
  logic [7:0]  out_en_lvl;
  logic        irq_lvl;

  int tests;
  int fails;

  avalon_pio_gen #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hFF),
    .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_en(out_en), .irq(irq)
  );

  avalon_pio_gen #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hFF),
    .EDGE_TYPE(0), .IRQ_TYPE(0), .SYNC_STAGES(2)
  ) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_lvl),
    .in_port(in_port), .out_port(out_port_lvl), .out_en(out_en_lvl), .irq(irq_lvl)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle bus write; returns 1 ns after the edge that commits it.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  // Combinational read: set address and let readdata settle.
  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] rd;

  initial begin
    tests      = 0;
    fails      = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;

    // Reset values, checked while reset is still asserted.
    #12;
    chk("rst_out_port", {24'h0, out_port}, 32'h0000_00A5);
    chk("rst_out_en",   {24'h0, out_en},   32'h0000_00FF);
    chk("rst_irq",      {31'h0, irq},      32'h0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_out_port", {24'h0, out_port}, 32'h0000_00A5);
    chk("post_rst_irq_lvl",  {31'h0, irq_lvl},  32'h0);
    bus_read(3'd0, rd);
    chk("rst_read_a0", rd, 32'h0000_00A5);

    // Data write, atomic set, atomic clear.
    bus_write(3'd0, 32'h0000_000F);
    chk("wr_data",   {24'h0, out_port}, 32'h0000_000F);
    bus_write(3'd4, 32'h0000_0030);
    chk("wr_outset", {24'h0, out_port}, 32'h0000_003F);
    bus_write(3'd5, 32'h0000_0003);
    chk("wr_outclr", {24'h0, out_port}, 32'h0000_003C);
    bus_write(3'd0, 32'hFFFF_FF00);
    chk("wr_upper_ignored", {24'h0, out_port}, 32'h0000_0000);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read(3'd0, rd);
    chk("read_upper_zero", rd, 32'h0000_00FF);
    bus_write(3'd0, 32'h0000_0000);
    bus_write(3'd4, 32'h0000_0001);
    chk("b2b_set", {24'h0, out_port}, 32'h0000_0001);
    bus_write(3'd5, 32'h0000_0001);
    chk("b2b_clr", {24'h0, out_port}, 32'h0000_0000);

    // Edge capture and edge interrupt on bit 2.
    bus_write(3'd1, 32'h0000_0000);
    chk("dir_in", {24'h0, out_en}, 32'h0000_0000);
    bus_write(3'd2, 32'h0000_0004);
    bus_read(3'd2, rd);
    chk("mask_read", rd, 32'h0000_0004);
    bus_read(3'd3, rd);
    chk("edge_idle", rd, 32'h0000_0000);
    in_port = 8'h04;
    tick();                               // edge k
    bus_read(3'd3, rd);
    chk("edge_k", rd, 32'h0000_0000);
    tick();                               // edge k+1
    bus_read(3'd3, rd);
    chk("edge_k1", rd, 32'h0000_0000);
    chk("irq_k1", {31'h0, irq}, 32'h0);
    tick();                               // edge k+2
    bus_read(3'd3, rd);
    chk("edge_k2", rd, 32'h0000_0004);
    chk("irq_k2",  {31'h0, irq}, 32'h1);
    bus_write(3'd3, 32'h0000_0004);
    bus_read(3'd3, rd);
    chk("edge_w1c", rd, 32'h0000_0000);
    chk("irq_w1c",  {31'h0, irq}, 32'h0);
    in_port = 8'h00;
    tick(); tick(); tick(); tick();
    bus_read(3'd3, rd);
    chk("fall_ignored", rd, 32'h0000_0000);
    chk("fall_irq",     {31'h0, irq}, 32'h0);

    // Capture versus clear in the same cycle: the capture wins.
    in_port = 8'h04;
    tick(); tick(); tick();
    bus_read(3'd3, rd);
    chk("coll_pre", rd, 32'h0000_0004);
    in_port = 8'h00;
    tick(); tick(); tick();
    in_port = 8'h04;
    tick();                               // edge k
    tick();                               // edge k+1: rise now asserted
    bus_write(3'd3, 32'h0000_0004);       // commits on edge k+2 with capture
    bus_read(3'd3, rd);
    chk("coll_edge", rd, 32'h0000_0004);
    chk("coll_irq",  {31'h0, irq}, 32'h1);
    bus_write(3'd3, 32'h0000_0004);
    bus_read(3'd3, rd);
    chk("coll_after", rd, 32'h0000_0000);

    // Mixed-direction read and level interrupt.
    bus_write(3'd1, 32'h0000_00F0);
    bus_write(3'd0, 32'h0000_00A0);
    in_port = 8'h05;
    tick(); tick();
    bus_read(3'd0, rd);
    chk("mixed_read", rd, 32'h0000_00A5);
    bus_write(3'd2, 32'h0000_0001);
    chk("lvl_irq_hi", {31'h0, irq_lvl}, 32'h1);
    in_port = 8'h04;
    tick();
    chk("lvl_irq_k",  {31'h0, irq_lvl}, 32'h1);
    tick();
    chk("lvl_irq_k1", {31'h0, irq_lvl}, 32'h0);
    in_port = 8'h05;
    tick();
    chk("lvl_rise_k",  {31'h0, irq_lvl}, 32'h0);
    tick();
    chk("lvl_rise_k1", {31'h0, irq_lvl}, 32'h1);

    // Unused addresses read zero; writes to 6/7 change nothing.
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    chk("unused_wr_out", {24'h0, out_port}, 32'h0000_00A0);
    chk("unused_wr_dir", {24'h0, out_en},   32'h0000_00F0);

    // Build edge_capture = 0xFF and data = 0x55, then async reset mid-cycle.
    bus_write(3'd2, 32'h0000_0000);
    in_port = 8'h00;
    tick(); tick(); tick();
    in_port = 8'hFF;
    tick(); tick(); tick();
    bus_write(3'd0, 32'h0000_0055);
    bus_read(3'd3, rd);
    chk("pre_rst_edge", rd, 32'h0000_00FF);
    chk("pre_rst_out",  {24'h0, out_port}, 32'h0000_0055);
    bus_write(3'd2, 32'h0000_00FF);
    chk("pre_rst_irq",  {31'h0, irq}, 32'h1);
    #2;                                   // between clock edges
    reset_n = 1'b0;
    #1;
    chk("arst_out",  {24'h0, out_port}, 32'h0000_00A5);
    chk("arst_dir",  {24'h0, out_en},   32'h0000_00FF);
    chk("arst_irq",  {31'h0, irq},      32'h0);
    bus_read(3'd3, rd);
    chk("arst_edge", rd, 32'h0000_0000);
    bus_read(3'd2, rd);
    chk("arst_mask", rd, 32'h0000_0000);
    for (int a = 4; a < 8; a++) begin
      bus_read(3'(a), rd);
      chk($sformatf("read_a%0d", a), rd, 32'h0000_0000);
    end

    // Input high at reset release: rising edge captured after the synchroniser.
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    bus_read(3'd3, rd);
    chk("rel_edge_early", rd, 32'h0000_0000);
    tick();
    bus_read(3'd3, rd);
    chk("rel_edge", rd, 32'h0000_00FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
